// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction memory,
// and registers fetched words into the IF/ID boundary with a valid/ready handshake.
//
//   state | meaning
//   RUN   | fetching sequentially, or stalled on decode backpressure
//   HALT  | an all-zero word was seen; waits for a redirect or reset
//   ERR   | a misaligned redirect was seen; only reset leaves
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_a,
   input  logic [31:0] imem_rd,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4,
   output logic        halted,
   output logic        misalign_err,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_pc_plus4_q, out_pc_plus4_d;
   logic        misalign_q, misalign_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic        fire;
   logic        load_en;

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      out_valid_d    = out_valid_q;
      out_instr_d    = out_instr_q;
      out_pc_d       = out_pc_q;
      out_pc_plus4_d = out_pc_plus4_q;
      misalign_d     = misalign_q;
      fetch_count_d  = fetch_count_q;

      fire    = out_valid_q && out_ready;
      load_en = (state_q == RUN) && (!out_valid_q || out_ready) && !redirect_valid;

      // A handshake completes even in a redirect cycle; the flush only kills the next word.
      if (fire) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end

      if (redirect_valid) begin
         if (redirect_pc[1:0] != 2'b00) begin
            misalign_d  = 1'b1;
            out_valid_d = 1'b0;
            state_d     = ERR;
         end else if (state_q != ERR) begin
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
            state_d     = RUN;
         end
      end else if (load_en) begin
         if (imem_rd != 32'd0) begin
            out_instr_d    = imem_rd;
            out_pc_d       = pc_q;
            out_pc_plus4_d = pc_q + 32'd4;
            out_valid_d    = 1'b1;
            pc_d           = pc_q + 32'd4;
         end else begin
            out_valid_d = out_valid_q && !out_ready;
            state_d     = HALT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RUN;
         pc_q           <= RESET_PC;
         out_valid_q    <= 1'b0;
         out_instr_q    <= 32'd0;
         out_pc_q       <= 32'd0;
         out_pc_plus4_q <= 32'd0;
         misalign_q     <= 1'b0;
         fetch_count_q  <= 32'd0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         out_valid_q    <= out_valid_d;
         out_instr_q    <= out_instr_d;
         out_pc_q       <= out_pc_d;
         out_pc_plus4_q <= out_pc_plus4_d;
         misalign_q     <= misalign_d;
         fetch_count_q  <= fetch_count_d;
      end
   end

   assign imem_a       = pc_q;
   assign out_valid    = out_valid_q;
   assign out_instr    = out_instr_q;
   assign out_pc       = out_pc_q;
   assign out_pc_plus4 = out_pc_plus4_q;
   assign halted       = (state_q == HALT);
   assign misalign_err = misalign_q;
   assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of the fetch rules.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_a, imem_rd;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid, out_ready;
   logic [31:0] out_instr, out_pc, out_pc_plus4;
   logic        halted, misalign_err;
   logic [31:0] fetch_count;

   logic [31:0] imem_a_w, imem_rd_w;
   logic        out_valid_w;
   logic [31:0] out_instr_w, out_pc_w, out_pc_plus4_w;
   logic        halted_w, misalign_err_w;
   logic [31:0] fetch_count_w;

   logic [31:0] mem [16];

   int n_chk = 0;
   int n_err = 0;

   // behavioural model: mode 0 = running, 1 = halted, 2 = error
   int          m_mode;
   logic [31:0] m_pc, m_instr, m_opc, m_opc4, m_cnt;
   logic        m_v, m_err;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'd64) return mem[a[5:2]];
      return 32'd0;
   endfunction

   always_comb imem_rd = (imem_a < 32'd64) ? mem[imem_a[5:2]] : 32'd0;
   always_comb imem_rd_w = (imem_a_w == 32'hFFFF_FFFC) ? 32'h0050_0093 :
                           ((imem_a_w < 32'd64) ? mem[imem_a_w[5:2]] : 32'd0);

   instr_fetch_unit dut (
      .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .halted(halted),
      .misalign_err(misalign_err), .fetch_count(fetch_count)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .reset(reset), .imem_a(imem_a_w), .imem_rd(imem_rd_w),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid_w), .out_ready(out_ready), .out_instr(out_instr_w),
      .out_pc(out_pc_w), .out_pc_plus4(out_pc_plus4_w), .halted(halted_w),
      .misalign_err(misalign_err_w), .fetch_count(fetch_count_w)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_next();
      logic fire;
      logic [31:0] word;
      fire = m_v && out_ready;
      word = mem_word(m_pc);
      if (reset) begin
         m_mode = 0; m_pc = 32'd0; m_v = 1'b0; m_instr = 32'd0;
         m_opc = 32'd0; m_opc4 = 32'd0; m_err = 1'b0; m_cnt = 32'd0;
      end else begin
         if (fire) m_cnt = m_cnt + 32'd1;
         if (redirect_valid) begin
            if (redirect_pc % 4 != 0) begin
               m_err = 1'b1; m_v = 1'b0; m_mode = 2;
            end else if (m_mode != 2) begin
               m_pc = redirect_pc; m_v = 1'b0; m_mode = 0;
            end
         end else if (m_mode == 0 && (!m_v || out_ready)) begin
            if (word != 32'd0) begin
               m_instr = word; m_opc = m_pc; m_opc4 = m_pc + 32'd4;
               m_v = 1'b1; m_pc = m_pc + 32'd4;
            end else begin
               m_v = 1'b0; m_mode = 1;
            end
         end
      end
   endtask

   task automatic tick();
      // every accepted word must be exactly what memory holds at its address
      if (!reset && out_valid && out_ready)
         chk("hs_word", out_instr, mem_word(out_pc));
      model_next();
      @(posedge clk);
      @(negedge clk);
      chk("imem_a", imem_a, m_pc);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_v});
      chk("out_instr", out_instr, m_instr);
      chk("out_pc", out_pc, m_opc);
      chk("out_pc_plus4", out_pc_plus4, m_opc4);
      chk("halted", {31'd0, halted}, {31'd0, m_mode == 1});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
      chk("fetch_count", fetch_count, m_cnt);
   endtask

   task automatic do_reset();
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] cnt0;
      int r;
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
      mem[0] = 32'h0AB0_0093;
      mem[1] = 32'h0010_2523;
      mem[2] = 32'h00A0_2103;

      // reset values and straight-line program up to the zero word
      do_reset();
      chk("rst_imem_a", imem_a, 32'h0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      tick();
      chk("seq0_pc", out_pc, 32'h0);
      chk("seq0_instr", out_instr, 32'h0AB0_0093);
      chk("wrap_pc", out_pc_w, 32'hFFFF_FFFC);
      chk("wrap_pc4", out_pc_plus4_w, 32'h0);
      chk("wrap_imem_a", imem_a_w, 32'h0);
      chk("wrap_valid", {31'd0, out_valid_w}, 32'd1);
      tick();
      chk("seq1_pc", out_pc, 32'h4);
      chk("seq1_instr", out_instr, 32'h0010_2523);
      tick();
      chk("seq2_pc", out_pc, 32'h8);
      chk("seq2_instr", out_instr, 32'h00A0_2103);
      tick();
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_valid", {31'd0, out_valid}, 32'd0);
      chk("halt_imem_a", imem_a, 32'hC);
      chk("halt_count", fetch_count, 32'd3);

      // backpressure after the first capture
      do_reset();
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_instr", out_instr, 32'h0AB0_0093);
         chk("bp_pc", out_pc, 32'h0);
         chk("bp_imem_a", imem_a, 32'h4);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_resume_pc", out_pc, 32'h4);
      tick();
      chk("bp_resume_pc2", out_pc, 32'h8);

      // redirect flushes a held, unaccepted word
      do_reset();
      tick();
      tick();
      chk("rd_pre_pc", out_pc, 32'h4);
      out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8;
      tick();
      chk("rd_flush_valid", {31'd0, out_valid}, 32'd0);
      redirect_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("rd_tgt_pc", out_pc, 32'h8);
      chk("rd_tgt_instr", out_instr, 32'h00A0_2103);
      chk("rd_count", fetch_count, 32'd1);
      tick();
      chk("rd_halt", {31'd0, halted}, 32'd1);

      // leave HALT via redirect, then redirect with a simultaneous handshake
      redirect_valid = 1'b1; redirect_pc = 32'h4;
      tick();
      chk("unhalt", {31'd0, halted}, 32'd0);
      redirect_valid = 1'b0;
      tick();
      chk("unhalt_pc", out_pc, 32'h4);
      chk("unhalt_pc4", out_pc_plus4, 32'h8);
      cnt0 = fetch_count;
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      tick();
      chk("rd_hs_count", fetch_count, cnt0 + 32'd1);
      chk("rd_hs_valid", {31'd0, out_valid}, 32'd0);
      redirect_valid = 1'b0;
      tick();
      chk("rd_hs_pc", out_pc, 32'h0);

      // misaligned redirect is sticky and blocks later redirects
      redirect_valid = 1'b1; redirect_pc = 32'h6;
      tick();
      chk("mis_flag", {31'd0, misalign_err}, 32'd1);
      chk("mis_valid", {31'd0, out_valid}, 32'd0);
      redirect_pc = 32'h0;
      tick();
      chk("mis_sticky", {31'd0, misalign_err}, 32'd1);
      chk("mis_ignored", imem_a, 32'h4);
      redirect_valid = 1'b0;
      do_reset();
      chk("mis_rst_flag", {31'd0, misalign_err}, 32'd0);
      chk("mis_rst_pc", imem_a, 32'h0);

      // randomized traffic
      for (int i = 0; i < 16; i++)
         mem[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom() | 32'd1);
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         reset = ($urandom_range(0, 39) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         r = $urandom_range(0, 99);
         redirect_valid = (r < 12);
         redirect_pc = 32'($urandom_range(0, 15)) << 2;
         if (r == 0) redirect_pc = redirect_pc + 32'($urandom_range(1, 3));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
